// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the two-port memory arbiter:
//   arbState_t    - FSM state encoding (IDLE=0, ACCESS=1, ACK=2)
//   PORT_CPU/AUX  - port index constants used for grant/last-grant values
//   LAT_CNT_BITS  - width of the latency down-counter (MEM_LATENCY 1..15)
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_ACK    = 2'd2
    } arbState_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam int LAT_CNT_BITS = 4;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2
// Combinational two-way round-robin picker.
// Ports:
//   req0, req1  in   request lines of port 0 / port 1
//   lastGrant   in   port that won the previous arbitration
//   valid       out  at least one request is pending
//   grant       out  winning port index (meaningful only when valid)
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic lastGrant,
    output logic valid,
    output logic grant
);

    always_comb begin
        valid = req0 | req1;
        grant = PORT_CPU;
        if (req0 && req1) begin
            // Contention: the port that did not win last time goes first.
            grant = (lastGrant == PORT_CPU) ? PORT_AUX : PORT_CPU;
        end else if (req1) begin
            grant = PORT_AUX;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one word-addressed memory port between two requesters
// (port 0 = CPU path, port 1 = auxiliary master such as DMA/loader).
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   reqN/wrN/addrN/wdataN   port N request, direction, address, write data
//   rdataN, ackN            port N registered read data, one-cycle completion
//   MAR/MBR_W/write         memory address, write data, write enable
//   MBR_R                   memory read data
//   dbgState                current FSM state, for observation only
//
// Handshake: a requester raises reqN with wrN/addrN/wdataN stable and keeps
// it high until ackN. ackN is high for exactly one cycle (the ACK state);
// reqN is ignored during that cycle, and reqN still high in the following
// IDLE cycle is treated as a new access.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int BITS_DATA   = 32,
    parameter int BITS_ADDR   = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 wr0,
    input  logic [BITS_ADDR-1:0] addr0,
    input  logic [BITS_DATA-1:0] wdata0,
    output logic [BITS_DATA-1:0] rdata0,
    output logic                 ack0,
    input  logic                 req1,
    input  logic                 wr1,
    input  logic [BITS_ADDR-1:0] addr1,
    input  logic [BITS_DATA-1:0] wdata1,
    output logic [BITS_DATA-1:0] rdata1,
    output logic                 ack1,
    output logic [BITS_ADDR-1:0] MAR,
    output logic [BITS_DATA-1:0] MBR_W,
    output logic                 write,
    input  logic [BITS_DATA-1:0] MBR_R,
    output arbState_t            dbgState
);

    arbState_t               state;
    logic                    lastGrant;
    logic [LAT_CNT_BITS-1:0] latCnt;
    logic                    pickValid;
    logic                    pickGrant;

    rr_pick2 u_pick (
        .req0      (req0),
        .req1      (req1),
        .lastGrant (lastGrant),
        .valid     (pickValid),
        .grant     (pickGrant)
    );

    assign dbgState = state;

    // lastGrant doubles as the index of the port being served while in
    // ACCESS/ACK, since it is loaded with the winner on the grant edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB_IDLE;
            MAR       <= '0;
            MBR_W     <= '0;
            write     <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            latCnt    <= '0;
            lastGrant <= PORT_AUX;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pickValid) begin
                        MAR       <= (pickGrant == PORT_AUX) ? addr1  : addr0;
                        MBR_W     <= (pickGrant == PORT_AUX) ? wdata1 : wdata0;
                        write     <= (pickGrant == PORT_AUX) ? wr1    : wr0;
                        lastGrant <= pickGrant;
                        latCnt    <= LAT_CNT_BITS'(MEM_LATENCY - 1);
                        state     <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    if (latCnt != '0) begin
                        latCnt <= latCnt - 1'b1;
                    end else begin
                        // write still carries the access direction here.
                        write <= 1'b0;
                        if (lastGrant == PORT_AUX) begin
                            ack1 <= 1'b1;
                            if (!write) rdata1 <= MBR_R;
                        end else begin
                            ack0 <= 1'b1;
                            if (!write) rdata0 <= MBR_R;
                        end
                        state <= ARB_ACK;
                    end
                end
                ARB_ACK: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- DUT A (MEM_LATENCY=1) ----------------
    logic a_req0 = 0, a_wr0 = 0, a_req1 = 0, a_wr1 = 0;
    logic [15:0] a_addr0 = 0, a_addr1 = 0;
    logic [31:0] a_wdata0 = 0, a_wdata1 = 0;
    logic [31:0] a_rdata0, a_rdata1, a_mbr_w, a_mbr_r;
    logic a_ack0, a_ack1, a_write;
    logic [15:0] a_mar;
    arbState_t a_state;
    logic [31:0] mem_a [256];

    mem_port_arbiter #(.BITS_DATA(32), .BITS_ADDR(16), .MEM_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset),
        .req0(a_req0), .wr0(a_wr0), .addr0(a_addr0), .wdata0(a_wdata0),
        .rdata0(a_rdata0), .ack0(a_ack0),
        .req1(a_req1), .wr1(a_wr1), .addr1(a_addr1), .wdata1(a_wdata1),
        .rdata1(a_rdata1), .ack1(a_ack1),
        .MAR(a_mar), .MBR_W(a_mbr_w), .write(a_write), .MBR_R(a_mbr_r),
        .dbgState(a_state)
    );

    assign a_mbr_r = mem_a[a_mar[7:0]];
    always @(posedge clk) begin
        if (reset) begin
            mem_a[8'h10] <= 32'hDEADBEEF;
            mem_a[8'h20] <= 32'hCAFEF00D;
        end else if (a_write) begin
            mem_a[a_mar[7:0]] <= a_mbr_w;
        end
    end

    // ---------------- DUT B (MEM_LATENCY=3) ----------------
    logic b_req0 = 0, b_wr0 = 0, b_req1 = 0, b_wr1 = 0;
    logic [15:0] b_addr0 = 0, b_addr1 = 0;
    logic [31:0] b_wdata0 = 0, b_wdata1 = 0;
    logic [31:0] b_rdata0, b_rdata1, b_mbr_w, b_mbr_r;
    logic b_ack0, b_ack1, b_write;
    logic [15:0] b_mar;
    arbState_t b_state;
    logic [31:0] mem_b [256];

    mem_port_arbiter #(.BITS_DATA(32), .BITS_ADDR(16), .MEM_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset),
        .req0(b_req0), .wr0(b_wr0), .addr0(b_addr0), .wdata0(b_wdata0),
        .rdata0(b_rdata0), .ack0(b_ack0),
        .req1(b_req1), .wr1(b_wr1), .addr1(b_addr1), .wdata1(b_wdata1),
        .rdata1(b_rdata1), .ack1(b_ack1),
        .MAR(b_mar), .MBR_W(b_mbr_w), .write(b_write), .MBR_R(b_mbr_r),
        .dbgState(b_state)
    );

    assign b_mbr_r = mem_b[b_mar[7:0]];
    always @(posedge clk) begin
        if (reset) begin
            mem_b[8'h10] <= 32'hDEADBEEF;
        end else if (b_write) begin
            mem_b[b_mar[7:0]] <= b_mbr_w;
        end
    end

    // ---------------- scoreboard state ----------------
    logic [31:0] ref_mem [256];
    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];
    logic [31:0] cur0, cur1;    // rdata model at push time
    logic [31:0] hold0, hold1;  // rdata model at ack time

    // Push the expected rdata for one access on one port.
    task automatic sb_push(input logic port, input logic wr, input logic [15:0] addr,
                           input logic [31:0] wdata);
        if (wr) begin
            ref_mem[addr[7:0]] = wdata;
        end else begin
            if (port) cur1 = ref_mem[addr[7:0]];
            else      cur0 = ref_mem[addr[7:0]];
        end
        if (port) exp1_q.push_back(cur1);
        else      exp0_q.push_back(cur0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        a_req0 = 0; a_req1 = 0; b_req0 = 0; b_req1 = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cur0 = '0; cur1 = '0; hold0 = '0; hold1 = '0;
        exp0_q.delete();
        exp1_q.delete();
        ref_mem[8'h10] = 32'hDEADBEEF;
        ref_mem[8'h20] = 32'hCAFEF00D;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (a_write !== 1'b0) begin failures++; $display("FAIL reset_write: got %b expected 0", a_write); end
            checks++;
            if (a_mar !== 16'h0) begin failures++; $display("FAIL reset_mar: got %h expected 0000", a_mar); end
            checks++;
            if ({a_ack0, a_ack1} !== 2'b00) begin failures++; $display("FAIL reset_ack: got %b expected 00", {a_ack0, a_ack1}); end
            checks++;
            if ({a_rdata0, a_rdata1} !== 64'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", {a_rdata0, a_rdata1}); end
            checks++;
            if (a_state !== ARB_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected 0", a_state); end
        end
        checks++;
        if ({b_write, b_ack0, b_ack1, b_mar} !== 19'h0) begin
            failures++; $display("FAIL reset_dut_b: got %h expected 0", {b_write, b_ack0, b_ack1, b_mar});
        end
    endtask

    // Single-port access on DUT A with exact MEM_LATENCY=1 timing checks.
    task automatic run_access(input logic port, input logic wr, input logic [15:0] addr,
                              input logic [31:0] wdata, input string name);
        logic [31:0] e;
        @(negedge clk);
        sb_push(port, wr, addr, wdata);
        if (port) begin a_wr1 = wr; a_addr1 = addr; a_wdata1 = wdata; a_req1 = 1; end
        else      begin a_wr0 = wr; a_addr0 = addr; a_wdata0 = wdata; a_req0 = 1; end
        @(negedge clk);
        checks++;
        if (a_state !== ARB_ACCESS) begin failures++; $display("FAIL %s_state_access: got %0d expected 1", name, a_state); end
        checks++;
        if (a_mar !== addr) begin failures++; $display("FAIL %s_mar: got %h expected %h", name, a_mar, addr); end
        checks++;
        if (a_write !== wr) begin failures++; $display("FAIL %s_write: got %b expected %b", name, a_write, wr); end
        if (wr) begin
            checks++;
            if (a_mbr_w !== wdata) begin failures++; $display("FAIL %s_mbr_w: got %h expected %h", name, a_mbr_w, wdata); end
        end
        checks++;
        if ({a_ack0, a_ack1} !== 2'b00) begin failures++; $display("FAIL %s_early_ack: got %b expected 00", name, {a_ack0, a_ack1}); end
        @(negedge clk);
        checks++;
        if (a_write !== 1'b0) begin failures++; $display("FAIL %s_write_drop: got %b expected 0", name, a_write); end
        checks++;
        if ({a_ack0, a_ack1} !== (port ? 2'b01 : 2'b10)) begin
            failures++; $display("FAIL %s_ack: got %b expected %b", name, {a_ack0, a_ack1}, (port ? 2'b01 : 2'b10));
        end
        checks++;
        if ((port ? exp1_q.size() : exp0_q.size()) == 0) begin
            failures++; $display("FAIL %s_sb_empty: got 0 expected 1 entry", name);
        end else if (port) begin
            e = exp1_q.pop_front(); hold1 = e;
            if (a_rdata1 !== e) begin failures++; $display("FAIL %s_rdata1: got %h expected %h", name, a_rdata1, e); end
            checks++;
            if (a_rdata0 !== hold0) begin failures++; $display("FAIL %s_rdata0_kept: got %h expected %h", name, a_rdata0, hold0); end
        end else begin
            e = exp0_q.pop_front(); hold0 = e;
            if (a_rdata0 !== e) begin failures++; $display("FAIL %s_rdata0: got %h expected %h", name, a_rdata0, e); end
            checks++;
            if (a_rdata1 !== hold1) begin failures++; $display("FAIL %s_rdata1_kept: got %h expected %h", name, a_rdata1, hold1); end
        end
        a_req0 = 0; a_req1 = 0;
        @(negedge clk);
        checks++;
        if ({a_ack0, a_ack1} !== 2'b00 || a_state !== ARB_IDLE) begin
            failures++; $display("FAIL %s_ack_end: got ack=%b state=%0d expected ack=00 state=0", name, {a_ack0, a_ack1}, a_state);
        end
    endtask

    task automatic test_alternate();
        int order[4];
        int n;
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            sb_push(1'b0, 1'b0, 16'h0010, 32'h0);
            sb_push(1'b1, 1'b0, 16'h0020, 32'h0);
        end
        a_wr0 = 0; a_addr0 = 16'h0010; a_req0 = 1;
        a_wr1 = 0; a_addr1 = 16'h0020; a_req1 = 1;
        n = 0;
        for (int cyc = 0; cyc < 30 && n < 4; cyc++) begin
            @(negedge clk);
            if (a_ack0 && a_ack1) begin failures++; $display("FAIL alt_both_ack: got 11 expected one-hot"); end
            if (a_ack0 && exp0_q.size() > 0) begin
                order[n] = 0; n++;
                e = exp0_q.pop_front(); hold0 = e;
                checks++;
                if (a_rdata0 !== e) begin failures++; $display("FAIL alt_rdata0: got %h expected %h", a_rdata0, e); end
                checks++;
                if (a_rdata1 !== hold1) begin failures++; $display("FAIL alt_rdata1_kept: got %h expected %h", a_rdata1, hold1); end
            end else if (a_ack1 && exp1_q.size() > 0) begin
                order[n] = 1; n++;
                e = exp1_q.pop_front(); hold1 = e;
                checks++;
                if (a_rdata1 !== e) begin failures++; $display("FAIL alt_rdata1: got %h expected %h", a_rdata1, e); end
                checks++;
                if (a_rdata0 !== hold0) begin failures++; $display("FAIL alt_rdata0_kept: got %h expected %h", a_rdata0, hold0); end
            end
            if (n == 4) begin a_req0 = 0; a_req1 = 0; end
        end
        a_req0 = 0; a_req1 = 0;
        checks++;
        if (n != 4) begin failures++; $display("FAIL alt_ack_count: got %0d expected 4", n); end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (order[i] != (i % 2)) begin failures++; $display("FAIL alt_order%0d: got %0d expected %0d", i, order[i], i % 2); end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({a_ack0, a_ack1} !== 2'b00) begin failures++; $display("FAIL alt_trailing_ack: got %b expected 00", {a_ack0, a_ack1}); end
        end
    endtask

    task automatic test_latency();
        do_reset();
        b_wr0 = 0; b_addr0 = 16'h0010; b_req0 = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (b_mar !== 16'h0010 || b_ack0 !== 1'b0 || b_write !== 1'b0) begin
                failures++; $display("FAIL lat3_hold%0d: got mar=%h ack=%b wr=%b expected mar=0010 ack=0 wr=0", k, b_mar, b_ack0, b_write);
            end
        end
        @(negedge clk);
        checks++;
        if (b_ack0 !== 1'b1) begin failures++; $display("FAIL lat3_ack: got %b expected 1", b_ack0); end
        checks++;
        if (b_rdata0 !== 32'hDEADBEEF) begin failures++; $display("FAIL lat3_rdata: got %h expected deadbeef", b_rdata0); end
        b_req0 = 0;
        @(negedge clk);
        checks++;
        if (b_ack0 !== 1'b0) begin failures++; $display("FAIL lat3_ack_pulse: got %b expected 0", b_ack0); end
    endtask

    task automatic test_reset_abort();
        logic got0, got1, first_is0;
        logic [31:0] e;
        @(negedge clk);
        a_wr1 = 1; a_addr1 = 16'h0030; a_wdata1 = 32'h55AA55AA; a_req1 = 1;
        @(negedge clk);
        checks++;
        if (a_write !== 1'b1 || a_state !== ARB_ACCESS) begin
            failures++; $display("FAIL abort_pre: got wr=%b state=%0d expected wr=1 state=1", a_write, a_state);
        end
        reset = 1'b1;
        a_wr0 = 0; a_addr0 = 16'h0010; a_req0 = 1;
        @(negedge clk);
        checks++;
        if (a_write !== 1'b0) begin failures++; $display("FAIL abort_write: got %b expected 0", a_write); end
        checks++;
        if (a_state !== ARB_IDLE) begin failures++; $display("FAIL abort_state: got %0d expected 0", a_state); end
        checks++;
        if ({a_ack0, a_ack1} !== 2'b00) begin failures++; $display("FAIL abort_ack: got %b expected 00", {a_ack0, a_ack1}); end
        reset = 1'b0;
        cur0 = '0; cur1 = '0; hold0 = '0; hold1 = '0;
        exp0_q.delete(); exp1_q.delete();
        sb_push(1'b0, 1'b0, 16'h0010, 32'h0);
        sb_push(1'b1, 1'b1, 16'h0030, 32'h55AA55AA);
        @(negedge clk);
        checks++;
        if (a_state !== ARB_ACCESS || a_mar !== 16'h0010 || a_write !== 1'b0) begin
            failures++; $display("FAIL abort_first_grant: got state=%0d mar=%h wr=%b expected state=1 mar=0010 wr=0", a_state, a_mar, a_write);
        end
        got0 = 0; got1 = 0; first_is0 = 0;
        for (int cyc = 0; cyc < 20 && !(got0 && got1); cyc++) begin
            @(negedge clk);
            if (a_ack0 && a_ack1) begin failures++; $display("FAIL abort_both_ack: got 11 expected one-hot"); end
            if (a_ack0 && !got0) begin
                if (!got1) first_is0 = 1;
                got0 = 1; a_req0 = 0;
                e = exp0_q.pop_front(); hold0 = e;
                checks++;
                if (a_rdata0 !== e) begin failures++; $display("FAIL abort_rdata0: got %h expected %h", a_rdata0, e); end
            end else if (a_ack1 && !got1) begin
                got1 = 1; a_req1 = 0;
                e = exp1_q.pop_front(); hold1 = e;
                checks++;
                if (a_rdata1 !== e) begin failures++; $display("FAIL abort_rdata1: got %h expected %h", a_rdata1, e); end
            end
        end
        a_req0 = 0; a_req1 = 0;
        checks++;
        if (!(got0 && got1)) begin failures++; $display("FAIL abort_timeout: got acks=%b%b expected 11", got0, got1); end
        checks++;
        if (!first_is0) begin failures++; $display("FAIL abort_order: got port1 first expected port0 first"); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        logic p;
        logic [31:0] wd;
        test_reset();
        run_access(1'b0, 1'b0, 16'h0010, 32'h0, "rd0_0010");
        run_access(1'b1, 1'b1, 16'h00FF, 32'h12345678, "wr1_00ff");
        run_access(1'b0, 1'b0, 16'h00FF, 32'h0, "rd0_00ff");
        for (int i = 0; i < 4; i++) begin
            p = 1'($urandom_range(0, 1));
            wd = $urandom;
            run_access(p, 1'b1, 16'h0040 + 16'(i), wd, "rnd_wr");
            p = 1'($urandom_range(0, 1));
            run_access(p, 1'b0, 16'h0040 + 16'(i), 32'h0, "rnd_rd");
        end
        test_alternate();
        test_latency();
        test_reset_abort();
        run_access(1'b1, 1'b0, 16'h0030, 32'h0, "rd1_0030");
        checks++;
        if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
            failures++; $display("FAIL sb_leftover: got %0d/%0d expected 0/0", exp0_q.size(), exp1_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
